// File: rtl/dvi_tmds_encoder_pkg.sv
// Shared video types for the DVI output path: TMDS character type, control
// tokens, the clock-channel character and small encoding helpers.
package dvi_tmds_encoder_pkg;

    typedef logic [9:0] tmds_char_t;

    localparam tmds_char_t CTL00         = 10'h354;
    localparam tmds_char_t CTL01         = 10'h0AB;
    localparam tmds_char_t CTL10         = 10'h154;
    localparam tmds_char_t CTL11         = 10'h2AB;
    localparam tmds_char_t TMDS_CLK_CHAR = 10'h01F;

    function automatic tmds_char_t ctl_token(input logic [1:0] c);
        tmds_char_t tok;
        case (c)
            2'b00:   tok = CTL00;
            2'b01:   tok = CTL01;
            2'b10:   tok = CTL10;
            default: tok = CTL11;
        endcase
        return tok;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimising first stage; bit 8 is 1 for the XOR path, 0 for XNOR.
    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [3:0] ones;
        logic       use_xnor;
        logic [7:0] qm;
        ones     = popcount8(d);
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        return {~use_xnor, qm};
    endfunction

endpackage

// File: rtl/dvi_tmds_encoder_channel.sv
// One TMDS channel: registered transition-minimising stage, then a registered
// DC-balancing stage with its own running disparity.
module tmds_channel_encoder
    import dvi_tmds_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       de,
    input  logic [1:0] c,
    input  logic [7:0] d,
    output logic [9:0] q
);

    logic [8:0] qm_c;
    logic [8:0] qm_s1;
    logic [3:0] n1_s1;
    logic       de_s1;
    logic [1:0] c_s1;

    logic [4:0] cnt;
    logic [4:0] cnt_nxt;
    tmds_char_t q_nxt;

    logic signed [5:0] cnt6;
    logic signed [5:0] n1;
    logic signed [5:0] n0;
    logic signed [5:0] cnt_sum;
    logic              qm8;

    assign qm_c = tmds_qm(d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qm_s1 <= 9'd0;
            n1_s1 <= 4'd0;
            de_s1 <= 1'b0;
            c_s1  <= 2'b00;
        end else if (en) begin
            qm_s1 <= qm_c;
            n1_s1 <= popcount8(qm_c[7:0]);
            de_s1 <= de;
            c_s1  <= c;
        end
    end

    // Disparity math runs at 6 bits signed; cnt itself never leaves -8..+8.
    always_comb begin
        qm8     = qm_s1[8];
        cnt6    = {cnt[4], cnt};
        n1      = {2'b00, n1_s1};
        n0      = 6'sd8 - n1;
        q_nxt   = ctl_token(c_s1);
        cnt_sum = 6'sd0;
        if (!de_s1) begin
            q_nxt   = ctl_token(c_s1);
            cnt_sum = 6'sd0;
        end else if ((cnt == 5'd0) || (n1_s1 == 4'd4)) begin
            q_nxt   = {~qm8, qm8, qm8 ? qm_s1[7:0] : ~qm_s1[7:0]};
            cnt_sum = qm8 ? (cnt6 + n1 - n0) : (cnt6 + n0 - n1);
        end else if ((!cnt[4] && (n1_s1 > 4'd4)) || (cnt[4] && (n1_s1 < 4'd4))) begin
            q_nxt   = {1'b1, qm8, ~qm_s1[7:0]};
            cnt_sum = cnt6 + (qm8 ? 6'sd2 : 6'sd0) + n0 - n1;
        end else begin
            q_nxt   = {1'b0, qm8, qm_s1[7:0]};
            cnt_sum = cnt6 + n1 - n0 - (qm8 ? 6'sd0 : 6'sd2);
        end
        cnt_nxt = cnt_sum[4:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q   <= CTL00;
            cnt <= 5'd0;
        end else if (en) begin
            q   <= q_nxt;
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/dvi_tmds_encoder.sv
// DVI TMDS encoder: three independent channel encoders plus the constant
// clock-channel character. Sync rides on blue; green and red carry C=00.
module dvi_tmds_encoder
    import dvi_tmds_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        de,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [23:0] rgb,
    output logic [9:0]  tmds_b,
    output logic [9:0]  tmds_g,
    output logic [9:0]  tmds_r,
    output logic [9:0]  tmds_clk
);

    tmds_channel_encoder u_ch_b (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .de    (de),
        .c     ({vsync, hsync}),
        .d     (rgb[7:0]),
        .q     (tmds_b)
    );

    tmds_channel_encoder u_ch_g (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .de    (de),
        .c     (2'b00),
        .d     (rgb[15:8]),
        .q     (tmds_g)
    );

    tmds_channel_encoder u_ch_r (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .de    (de),
        .c     (2'b00),
        .d     (rgb[23:16]),
        .q     (tmds_r)
    );

    assign tmds_clk = TMDS_CLK_CHAR;

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Directed and randomised checks of the DVI TMDS encoder against hand-computed
// characters and an independent behavioural encoder.
module tb_dvi_tmds_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        de = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [23:0] rgb = 24'd0;
    logic [9:0]  tmds_b;
    logic [9:0]  tmds_g;
    logic [9:0]  tmds_r;
    logic [9:0]  tmds_clk;

    int checks = 0;
    int errors = 0;
    int cnt_b, cnt_g, cnt_r;
    logic [29:0] exp_q[$];

    always #5 clk = ~clk;

    dvi_tmds_encoder dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .de       (de),
        .hsync    (hsync),
        .vsync    (vsync),
        .rgb      (rgb),
        .tmds_b   (tmds_b),
        .tmds_g   (tmds_g),
        .tmds_r   (tmds_r),
        .tmds_clk (tmds_clk)
    );

    task automatic ref_enc(input logic [7:0] d, input logic de_i, input logic [1:0] c,
                           inout int cnt, output logic [9:0] ch);
        int ones;
        int n1;
        logic inv;
        logic qm8;
        logic [7:0] qm;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        inv   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = inv ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm8 = ~inv;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
        if (!de_i) begin
            case (c)
                2'b00:   ch = 10'h354;
                2'b01:   ch = 10'h0AB;
                2'b10:   ch = 10'h154;
                default: ch = 10'h2AB;
            endcase
            cnt = 0;
        end else if (cnt == 0 || n1 == 4) begin
            if (qm8) begin
                ch = {2'b01, qm};
                cnt += 2 * n1 - 8;
            end else begin
                ch = {2'b10, ~qm};
                cnt += 8 - 2 * n1;
            end
        end else if ((cnt > 0 && n1 > 4) || (cnt < 0 && n1 < 4)) begin
            ch = {1'b1, qm8, ~qm};
            cnt += (qm8 ? 2 : 0) + 8 - 2 * n1;
        end else begin
            ch = {1'b0, qm8, qm};
            cnt += 2 * n1 - 8 - (qm8 ? 0 : 2);
        end
    endtask

    // Drives one cycle at a negedge, updates the model, returns at the next negedge.
    task automatic step(input logic en_i, input logic de_i, input logic hs, input logic vs,
                        input logic [23:0] px);
        logic [9:0] eb, eg, er;
        en = en_i;
        de = de_i;
        hsync = hs;
        vsync = vs;
        rgb = px;
        if (en_i) begin
            ref_enc(px[7:0], de_i, {vs, hs}, cnt_b, eb);
            ref_enc(px[15:8], de_i, 2'b00, cnt_g, eg);
            ref_enc(px[23:16], de_i, 2'b00, cnt_r, er);
            exp_q.push_back({er, eg, eb});
            if (exp_q.size() > 2) void'(exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        de = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        cnt_b = 0;
        cnt_g = 0;
        cnt_r = 0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if (tmds_b !== 10'h354) begin errors++; $display("FAIL reset_b got %h exp 354", tmds_b); end
        checks++;
        if (tmds_g !== 10'h354) begin errors++; $display("FAIL reset_g got %h exp 354", tmds_g); end
        checks++;
        if (tmds_r !== 10'h354) begin errors++; $display("FAIL reset_r got %h exp 354", tmds_r); end
        checks++;
        if (tmds_clk !== 10'h01F) begin errors++; $display("FAIL reset_clk got %h exp 01f", tmds_clk); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_blanking();
        logic [1:0] ctl_seq [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        logic [9:0] exp_b [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, ctl_seq[i][0], ctl_seq[i][1], 24'h5A3C96);
            if (i >= 1) begin
                checks++;
                if (tmds_b !== exp_b[i-1]) begin
                    errors++; $display("FAIL blank_b[%0d] got %h exp %h", i - 1, tmds_b, exp_b[i-1]);
                end
                checks++;
                if (tmds_g !== 10'h354 || tmds_r !== 10'h354) begin
                    errors++; $display("FAIL blank_gr[%0d] got %h/%h exp 354", i - 1, tmds_g, tmds_r);
                end
            end
        end
    endtask

    // B and R = 0x00, G = 0xFF; includes a blanking gap to confirm cnt clears.
    task automatic test_disparity();
        logic       de_seq [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [9:0] exp_b [7] = '{10'h100, 10'h3FF, 10'h100, 10'h354, 10'h354, 10'h100, 10'h354};
        logic [9:0] exp_g [7] = '{10'h200, 10'h0FF, 10'h0FF, 10'h354, 10'h354, 10'h200, 10'h354};
        int         exp_c [7] = '{-8, 2, -6, 0, 0, -8, 0};
        int         got_c;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, de_seq[i], 1'b0, 1'b0, 24'h00FF00);
            if (i >= 1) begin
                checks++;
                if (tmds_b !== exp_b[i-1]) begin
                    errors++; $display("FAIL disp_b[%0d] got %h exp %h", i - 1, tmds_b, exp_b[i-1]);
                end
                checks++;
                if (tmds_r !== exp_b[i-1]) begin
                    errors++; $display("FAIL disp_r[%0d] got %h exp %h", i - 1, tmds_r, exp_b[i-1]);
                end
                checks++;
                if (tmds_g !== exp_g[i-1]) begin
                    errors++; $display("FAIL disp_g[%0d] got %h exp %h", i - 1, tmds_g, exp_g[i-1]);
                end
                got_c = int'($signed(dut.u_ch_b.cnt));
                checks++;
                if (got_c != exp_c[i-1]) begin
                    errors++; $display("FAIL disp_cnt[%0d] got %0d exp %0d", i - 1, got_c, exp_c[i-1]);
                end
            end
        end
    endtask

    task automatic test_xnor();
        int got_c;
        apply_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'h0000FF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
        checks++;
        if (tmds_b !== 10'h200) begin errors++; $display("FAIL xnor_b got %h exp 200", tmds_b); end
        checks++;
        if (tmds_r !== 10'h100) begin errors++; $display("FAIL xnor_r got %h exp 100", tmds_r); end
        got_c = int'($signed(dut.u_ch_b.cnt));
        checks++;
        if (got_c != -8) begin errors++; $display("FAIL xnor_cnt got %0d exp -8", got_c); end
    endtask

    task automatic test_midline_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 24'h000000);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (tmds_b !== 10'h354 || tmds_g !== 10'h354 || tmds_r !== 10'h354) begin
            errors++; $display("FAIL midreset got %h/%h/%h exp 354", tmds_b, tmds_g, tmds_r);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        cnt_b = 0;
        cnt_g = 0;
        cnt_r = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'h000000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
        checks++;
        if (tmds_b !== 10'h100) begin errors++; $display("FAIL post_reset_b got %h exp 100", tmds_b); end
    endtask

    task automatic test_stall();
        logic       en_seq [14] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        logic       de_seq [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        logic [23:0] px [14] = '{24'h102030, 24'hF0E1D2, 24'h00FF10, 24'h7F8001,
                                 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000,
                                 24'hAA5533, 24'h0F0F0F, 24'hFEDCBA, 24'h000000, 24'h000000};
        logic [29:0] e;
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            step(en_seq[i], de_seq[i], 1'b0, 1'b0, px[i]);
            if (exp_q.size() == 2) begin
                e = exp_q[0];
                checks++;
                if ({tmds_r, tmds_g, tmds_b} !== e) begin
                    errors++; $display("FAIL stall[%0d] got %h_%h_%h exp %h_%h_%h", i,
                                       tmds_r, tmds_g, tmds_b, e[29:20], e[19:10], e[9:0]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic        de_state;
        logic [29:0] e;
        apply_reset();
        de_state = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 39) == 0) de_state = ~de_state;
            step($urandom_range(0, 7) != 0, de_state, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 24'($urandom()));
            if (exp_q.size() == 2) begin
                e = exp_q[0];
                checks++;
                if (tmds_b !== e[9:0]) begin
                    errors++; $display("FAIL rand_b[%0d] got %h exp %h", i, tmds_b, e[9:0]);
                end
                checks++;
                if (tmds_g !== e[19:10]) begin
                    errors++; $display("FAIL rand_g[%0d] got %h exp %h", i, tmds_g, e[19:10]);
                end
                checks++;
                if (tmds_r !== e[29:20]) begin
                    errors++; $display("FAIL rand_r[%0d] got %h exp %h", i, tmds_r, e[29:20]);
                end
                checks++;
                if (tmds_clk !== 10'h01F) begin
                    errors++; $display("FAIL rand_clk[%0d] got %h exp 01f", i, tmds_clk);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_blanking();
        test_disparity();
        test_xnor();
        test_midline_reset();
        test_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
